// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the in-order pipeline
// writeback and a long-latency unit whose results arrive out of band. The
// long-latency results wait in a small FIFO; the pipeline normally wins, but
// a starvation counter forces a one-cycle pipeline stall (DRAIN) so queued
// results always reach the register file.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_reg_write,
  input  logic [4:0]  pipe_rd_address,
  input  logic [31:0] pipe_wdata,
  input  logic        ll_valid,
  input  logic [4:0]  ll_rd_address,
  input  logic [31:0] ll_wdata,
  output logic        ll_ready,
  output logic        rf_write_enable,
  output logic [4:0]  rf_write_address,
  output logic [31:0] rf_write_data,
  output logic        pipe_stall
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [3:0]  LAST_WIN   = 4'(STARVE_LIMIT - 1);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [3:0]  r_starve;
  logic [3:0]  w_nextStarve;

  logic [AW:0] r_wrPtr;
  logic [AW:0] r_rdPtr;
  logic [4:0]  r_memRd   [DEPTH];
  logic [31:0] r_memData [DEPTH];

  logic [AW:0] w_count;
  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_store;
  logic        w_pipeActive;
  logic        w_grantPipe;
  logic        w_grantFifo;
  logic [4:0]  w_headRd;
  logic [31:0] w_headData;

  // Occupancy comes from the extra-bit pointers; the acceptance flag only
  // looks at registered state so a pop cannot make room in the same cycle.
  always_comb begin
    w_count      = r_wrPtr - r_rdPtr;
    w_empty      = (w_count == '0);
    w_full       = (w_count == FULL_COUNT);
    ll_ready     = !reset && !w_full;
    w_push       = ll_valid && ll_ready;
    w_store      = w_push && (ll_rd_address != 5'd0);
    w_pipeActive = pipe_reg_write && (pipe_rd_address != 5'd0);
    w_headRd     = r_memRd[r_rdPtr[AW-1:0]];
    w_headData   = r_memData[r_rdPtr[AW-1:0]];
  end

  // Grant decision: pipeline first in IDLE, FIFO head whenever the pipeline
  // is idle or the block is forcing a drain; reset blocks every write.
  always_comb begin
    w_grantPipe = 1'b0;
    w_grantFifo = 1'b0;
    if (!reset) begin
      case (r_state)
        IDLE: begin
          if (w_pipeActive) begin
            w_grantPipe = 1'b1;
          end else if (!w_empty) begin
            w_grantFifo = 1'b1;
          end
        end
        DRAIN: begin
          w_grantFifo = !w_empty;
        end
        default: begin
          w_grantFifo = 1'b0;
        end
      endcase
    end
  end

  // Next state and starvation count: count consecutive pipeline wins over a
  // waiting FIFO and schedule a drain on the last allowed win.
  always_comb begin
    w_nextState  = IDLE;
    w_nextStarve = r_starve;
    case (r_state)
      IDLE: begin
        if (w_grantFifo || w_empty) begin
          w_nextStarve = 4'd0;
        end else if (w_grantPipe) begin
          if (r_starve == LAST_WIN) begin
            w_nextState  = DRAIN;
            w_nextStarve = 4'd0;
          end else begin
            w_nextStarve = r_starve + 4'd1;
          end
        end
      end
      DRAIN: begin
        w_nextStarve = 4'd0;
      end
      default: begin
        w_nextStarve = 4'd0;
      end
    endcase
  end

  // Output mux: the register-file port follows whichever source is granted
  // and rests at zero otherwise; the stall is a pure function of the state.
  always_comb begin
    pipe_stall       = (r_state == DRAIN);
    rf_write_enable  = 1'b0;
    rf_write_address = 5'd0;
    rf_write_data    = 32'd0;
    if (w_grantPipe) begin
      rf_write_enable  = 1'b1;
      rf_write_address = pipe_rd_address;
      rf_write_data    = pipe_wdata;
    end else if (w_grantFifo) begin
      rf_write_enable  = 1'b1;
      rf_write_address = w_headRd;
      rf_write_data    = w_headData;
    end
  end

  // State and starvation counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_starve <= 4'd0;
    end else begin
      r_state  <= w_nextState;
      r_starve <= w_nextStarve;
    end
  end

  // FIFO pointers; results for x0 are acknowledged but never enqueued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_store) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_grantFifo) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
    end
  end

  // FIFO storage needs no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_memRd[r_wrPtr[AW-1:0]]   <= ll_rd_address;
      r_memData[r_wrPtr[AW-1:0]] <= ll_wdata;
    end
  end

endmodule
